// File: rtl/timer_unit_if.sv
// Bus bundle for timer_unit: programming strobe, interval request and
// expiry pulse. Optional status signals appear when TIMER_STATUS_EN is defined.
interface timer_unit_if;
   logic       Prog_Sync;
   logic [1:0] Time_Param_Selector;
   logic [3:0] Time_Value;
   logic [1:0] interval;
   logic       start_timer;
   logic       expired;
`ifdef TIMER_STATUS_EN
   logic       busy;
   logic [4:0] remaining;
`endif

   modport master (
      output Prog_Sync,
      output Time_Param_Selector,
      output Time_Value,
      output interval,
      output start_timer,
`ifdef TIMER_STATUS_EN
      input  busy,
      input  remaining,
`endif
      input  expired
   );

   modport slave (
      input  Prog_Sync,
      input  Time_Param_Selector,
      input  Time_Value,
      input  interval,
      input  start_timer,
`ifdef TIMER_STATUS_EN
      output busy,
      output remaining,
`endif
      output expired
   );
endinterface

// File: rtl/timer_unit.sv
// timer_unit: programmable seconds timer for the traffic-light controller.
// Three 4-bit durations (tBASE, tEXT, tYEL) are programmable; an interval
// request loads a countdown that ticks once per CLK_DIV clocks and emits a
// one-cycle expired pulse when it reaches zero.
// Optional macro TIMER_STATUS_EN adds busy/remaining outputs for the display.
module timer_unit #(
   parameter int CLK_DIV   = 100000000,
   parameter int TBASE_DEF = 6,
   parameter int TEXT_DEF  = 3,
   parameter int TYEL_DEF  = 2
) (
   input  logic         clk,
   input  logic         Reset,
   timer_unit_if.slave  bus
);

   localparam int            PW        = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [3:0]    TBASE_RST = 4'(TBASE_DEF);
   localparam logic [3:0]    TEXT_RST  = 4'(TEXT_DEF);
   localparam logic [3:0]    TYEL_RST  = 4'(TYEL_DEF);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        r_state, w_state_nx;
   logic [3:0]    r_tbase, r_text, r_tyel;
   logic [3:0]    w_tbase_nx, w_text_nx, w_tyel_nx;
   logic [4:0]    r_count, w_count_nx;
   logic [4:0]    w_dur;
   logic [PW-1:0] r_presc, w_presc_nx;
   logic          r_expired, w_expired_nx;

   // A programmed zero would mean a zero-length interval; substitute the default.
   function automatic logic [3:0] f_prog_val(input logic [3:0] val, input logic [3:0] def);
      return (val == 4'd0) ? def : val;
   endfunction

   // Next parameter values; the duration below sees these so a write and a
   // start in the same cycle use the freshly written value.
   always_comb begin
      w_tbase_nx = r_tbase;
      w_text_nx  = r_text;
      w_tyel_nx  = r_tyel;
      if (bus.Prog_Sync) begin
         case (bus.Time_Param_Selector)
            2'b00:   w_tbase_nx = f_prog_val(bus.Time_Value, TBASE_RST);
            2'b01:   w_text_nx  = f_prog_val(bus.Time_Value, TEXT_RST);
            2'b10:   w_tyel_nx  = f_prog_val(bus.Time_Value, TYEL_RST);
            default: ;
         endcase
      end
   end

   // Resolve the requested interval to a 5-bit duration (2*tBASE fits, max 30).
   always_comb begin
      case (bus.interval)
         2'b00:   w_dur = {1'b0, w_tbase_nx};
         2'b01:   w_dur = {1'b0, w_text_nx};
         2'b10:   w_dur = {1'b0, w_tyel_nx};
         default: w_dur = {w_tbase_nx, 1'b0};
      endcase
   end

   // Parameter registers.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_tbase <= TBASE_RST;
         r_text  <= TEXT_RST;
         r_tyel  <= TYEL_RST;
      end else begin
         r_tbase <= w_tbase_nx;
         r_text  <= w_text_nx;
         r_tyel  <= w_tyel_nx;
      end
   end

   // Countdown state register.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_count   <= 5'd0;
         r_presc   <= '0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_count   <= w_count_nx;
         r_presc   <= w_presc_nx;
         r_expired <= w_expired_nx;
      end
   end

   // Next-state logic: start beats abort, abort beats counting.
   always_comb begin
      w_state_nx   = r_state;
      w_count_nx   = r_count;
      w_presc_nx   = r_presc;
      w_expired_nx = 1'b0;
      if (bus.start_timer) begin
         w_state_nx = RUN;
         w_count_nx = w_dur;
         w_presc_nx = '0;
      end else if (bus.Prog_Sync) begin
         w_state_nx = IDLE;
         w_count_nx = 5'd0;
         w_presc_nx = '0;
      end else if (r_state == RUN) begin
         if (r_presc == PRESC_MAX) begin
            w_presc_nx = '0;
            w_count_nx = r_count - 5'd1;
            if (r_count == 5'd1) begin
               w_expired_nx = 1'b1;
               w_state_nx   = IDLE;
            end
         end else begin
            w_presc_nx = r_presc + PW'(1);
         end
      end
   end

   assign bus.expired = r_expired;

`ifdef TIMER_STATUS_EN
   assign bus.busy      = (r_state == RUN);
   assign bus.remaining = (r_state == RUN) ? r_count : 5'd0;
`endif

endmodule

// File: tb/tb_timer_unit.sv
// Bench for timer_unit with CLK_DIV=4: expected expiry cycles are queued
// when a start is driven and compared when the pulse is observed.
module tb_timer_unit;
   logic clk = 1'b0;
   logic Reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   timer_unit_if bus();

   timer_unit #(
      .CLK_DIV(4), .TBASE_DEF(6), .TEXT_DEF(3), .TYEL_DEF(2)
   ) dut (
      .clk(clk),
      .Reset(Reset),
      .bus(bus.slave)
   );

   task automatic idle_inputs();
      bus.Prog_Sync           = 1'b0;
      bus.Time_Param_Selector = 2'b11;
      bus.Time_Value          = 4'd0;
      bus.interval            = 2'b00;
      bus.start_timer         = 1'b0;
   endtask

   // Drive one start (optionally with a program write); s = sampling edge number.
   task automatic drive_start(input logic [1:0] iv, input logic prog, input logic [1:0] sel,
                              input logic [3:0] val, output int s);
      @(negedge clk);
      bus.interval            = iv;
      bus.start_timer         = 1'b1;
      bus.Prog_Sync           = prog;
      bus.Time_Param_Selector = sel;
      bus.Time_Value          = val;
      s = cyc + 1;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic drive_prog(input logic [1:0] sel, input logic [3:0] val);
      @(negedge clk);
      bus.Prog_Sync           = 1'b1;
      bus.Time_Param_Selector = sel;
      bus.Time_Value          = val;
      @(negedge clk);
      idle_inputs();
   endtask

   // Wait (bounded) for the first expired pulse; at = cycle seen, or -1.
   task automatic wait_expired(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.expired === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int at;
      idle_inputs();
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.expired !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_expired: got %b expected 0", bus.expired);
      end
`ifdef TIMER_STATUS_EN
      n_tests++;
      if (bus.busy !== 1'b0 || bus.remaining !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_status: got busy=%b rem=%0d expected 0/0", bus.busy, bus.remaining);
      end
`endif
      Reset = 1'b0;
      wait_expired(40, at);
      n_tests++;
      if (at !== -1) begin
         n_fail++;
         $display("FAIL idle_no_pulse: got pulse at %0d expected none", at);
      end
   endtask

   task automatic test_base();
      int s, at, exp;
      drive_start(2'b00, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 24);
      wait_expired(60, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL base_expire: got cycle %0d expected %0d", at, exp);
      end
      @(negedge clk);
      n_tests++;
      if (bus.expired !== 1'b0) begin
         n_fail++;
         $display("FAIL base_pulse_width: got %b expected 0", bus.expired);
      end
   endtask

   task automatic test_program();
      int s, at, exp;
      drive_prog(2'b10, 4'd5);
      drive_start(2'b10, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 20);
      wait_expired(60, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL prog_yel5: got cycle %0d expected %0d", at, exp);
      end
      drive_prog(2'b00, 4'd9);
      drive_prog(2'b00, 4'd0);
      drive_start(2'b11, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 48);
      wait_expired(100, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL prog_zero_default: got cycle %0d expected %0d", at, exp);
      end
      drive_start(2'b01, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 12);
      wait_expired(60, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL text_default: got cycle %0d expected %0d", at, exp);
      end
   endtask

   task automatic test_double_wide();
      int s, at, exp;
      drive_prog(2'b00, 4'd15);
      drive_start(2'b11, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 120);
      wait_expired(200, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL double_tbase15: got cycle %0d expected %0d", at, exp);
      end
   endtask

   task automatic test_restart();
      int s, s2, at, exp;
      drive_start(2'b01, 1'b0, 2'b11, 4'd0, s);
      while (cyc < s + 8) @(negedge clk);
      drive_start(2'b01, 1'b0, 2'b11, 4'd0, s2);
      sb.push_back(s + 22);
      wait_expired(60, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL restart: got cycle %0d expected %0d (restart edge %0d)", at, exp, s2 - s);
      end
   endtask

   task automatic test_abort();
      int s, at, exp;
      drive_start(2'b00, 1'b0, 2'b11, 4'd0, s);
      repeat (6) @(negedge clk);
      drive_prog(2'b11, 4'd7);
      wait_expired(100, at);
      n_tests++;
      if (at !== -1) begin
         n_fail++;
         $display("FAIL abort_no_pulse: got pulse at %0d expected none", at);
      end
      drive_start(2'b00, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 60);
      wait_expired(100, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL sel11_no_write: got cycle %0d expected %0d", at, exp);
      end
   endtask

   task automatic test_write_first();
      int s, at, exp;
      drive_start(2'b11, 1'b1, 2'b00, 4'd2, s);
      sb.push_back(s + 16);
`ifdef TIMER_STATUS_EN
      for (int k = 0; k < 4; k++) begin
         while (cyc < s + 4 * k) @(negedge clk);
         n_tests++;
         if (bus.remaining !== 5'(4 - k) || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL remaining_tick%0d: got rem=%0d busy=%b expected %0d/1",
                     k, bus.remaining, bus.busy, 4 - k);
         end
      end
`endif
      wait_expired(40, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL write_first: got cycle %0d expected %0d", at, exp);
      end
   endtask

   task automatic test_reset_mid_run();
      int s, at, exp;
      drive_prog(2'b10, 4'd5);
      drive_start(2'b10, 1'b0, 2'b11, 4'd0, s);
      wait_expired(60, at);
      #1 Reset = 1'b1;
      #1;
      n_tests++;
      if (bus.expired !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_clears: got %b expected 0", bus.expired);
      end
      @(negedge clk);
      Reset = 1'b0;
      drive_start(2'b11, 1'b0, 2'b11, 4'd0, s);
      repeat (5) @(negedge clk);
      #2 Reset = 1'b1;
      bus.start_timer         = 1'b1;
      bus.Prog_Sync           = 1'b1;
      bus.Time_Param_Selector = 2'b00;
      bus.Time_Value          = 4'd9;
      repeat (3) @(negedge clk);
      idle_inputs();
      Reset = 1'b0;
      wait_expired(80, at);
      n_tests++;
      if (at !== -1) begin
         n_fail++;
         $display("FAIL reset_mid_run_no_pulse: got pulse at %0d expected none", at);
      end
      drive_start(2'b00, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 24);
      wait_expired(60, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL reset_tbase_default: got cycle %0d expected %0d", at, exp);
      end
      drive_start(2'b10, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 8);
      wait_expired(60, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL reset_tyel_default: got cycle %0d expected %0d", at, exp);
      end
   endtask

   task automatic test_back_to_back();
      int s, s2, at, exp;
      drive_start(2'b10, 1'b0, 2'b11, 4'd0, s);
      sb.push_back(s + 8);
      wait_expired(40, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL b2b_first: got cycle %0d expected %0d", at, exp);
      end
      bus.interval    = 2'b10;
      bus.start_timer = 1'b1;
      s2 = cyc + 1;
      sb.push_back(s2 + 8);
      @(negedge clk);
      idle_inputs();
      n_tests++;
      if (bus.expired !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_pulse_width: got %b expected 0", bus.expired);
      end
      wait_expired(40, at);
      exp = sb.pop_front();
      n_tests++;
      if (at !== exp) begin
         n_fail++;
         $display("FAIL b2b_second: got cycle %0d expected %0d", at, exp);
      end
   endtask

   initial begin
      test_reset();
      test_base();
      test_program();
      test_double_wide();
      test_restart();
      test_abort();
      test_write_first();
      test_reset_mid_run();
      test_back_to_back();
      n_tests++;
      if (sb.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
